disp_scan_sched: RTL and testbench

Time-multiplexing scheduler for a shared common-anode 7-segment bus. It scans `ndig` BCD digits onto one `seg` bus and one active-low `an` enable per digit. Each digit slot begins with an anti-ghosting blank interval, and digit values are latched once per frame so the display does not tear. It sits between the counter/BCD converter path and the board display pins.

---
 rtl/disp_scan_sched_pkg.sv | 28 ++
 rtl/disp_scan_sched_bcd7seg_lut.sv | 28 ++
 rtl/disp_scan_sched.sv | 169 ++++++++++++++++
 tb/tb_disp_scan_sched.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/disp_scan_sched_pkg.sv
// disp_pkg: shared types and constants for the 7-segment scan scheduler.
//   scan_state_t : scheduler FSM states (IDLE, BLANK, DRIVE)
//   SEG_OFF      : all segments dark (active-low)
//   SEG_DASH     : middle bar only, used for non-BCD codes 10..15
//   SEG_0..SEG_9 : active-low digit patterns, bit order {g,f,e,d,c,b,a}
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/disp_scan_sched_bcd7seg_lut.sv
// bcd7seg_lut: combinational BCD to 7-segment decoder, active-low outputs.
//   bcd : 4-bit input code
//   seg : {g,f,e,d,c,b,a}, active-low; codes 10..15 decode to a dash
module bcd7seg_lut
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_scan_sched.sv
// disp_scan_sched: time-multiplexed scan scheduler for a shared common-anode
// 7-segment bus. Each digit slot opens with a blank interval to suppress
// ghosting, then drives one digit. Digit values are captured into a shadow
// register once per frame so a changing count never tears across digits.
//
// Parameters
//   fpga_freq  : clock frequency in Hz
//   refresh_hz : per-digit slot rate in Hz (SLOT = fpga_freq / refresh_hz)
//   ndig       : number of digits, 2..8
//   blank_cyc  : blank cycles at the start of every slot (1..SLOT-1)
// Ports
//   clk        : system clock
//   rst        : asynchronous reset, active-low
//   en         : display enable; 0 darkens the display on the next edge
//   digits     : BCD digits, digit i on [4i+3:4i], digit 0 rightmost
//   seg        : segments {g,f,e,d,c,b,a}, active-low, registered
//   an         : digit enables, active-low, at most one low, registered
//   frame_tick : one-cycle pulse on the last DRIVE cycle of each frame
// Build option
//   DISP_LEADING_ZERO_BLANK_EN : when defined, leading zero digits (all
//   digits from i up to the top are 0, i > 0) keep their anode off.
module disp_scan_sched
  import disp_pkg::*;
#(
  parameter int fpga_freq  = 50_000_000,
  parameter int refresh_hz = 1000,
  parameter int ndig       = 2,
  parameter int blank_cyc  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [4*ndig-1:0] digits,
  output logic [6:0]        seg,
  output logic [ndig-1:0]   an,
  output logic              frame_tick
);

  localparam int SLOT = fpga_freq / refresh_hz;
  localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int IW   = (ndig > 1) ? $clog2(ndig) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(blank_cyc - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(ndig - 1);

  generate
    if (!((SLOT > blank_cyc) && (blank_cyc >= 1))) begin : g_cfg_err
      $error("disp_scan_sched: need SLOT > blank_cyc and blank_cyc >= 1");
    end
  endgenerate

  scan_state_t             state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [ndig-1:0][3:0]    shadow, shadow_nxt;
  logic [3:0]              digit_sel;
  logic [6:0]              seg_dec;
  logic [6:0]              seg_nxt;
  logic [ndig-1:0]         an_nxt;
  logic                    tick_nxt;

`ifdef DISP_LEADING_ZERO_BLANK_EN
  // True when every shadow digit from position k upward is zero.
  function automatic logic upper_zero(input logic [ndig-1:0][3:0] d,
                                      input logic [IW-1:0] k);
    logic z;
    z = 1'b1;
    for (int i = 0; i < ndig; i++) begin
      if ((i >= int'(k)) && (d[i] != 4'd0)) z = 1'b0;
    end
    return z;
  endfunction
`endif

  // Next-state: slot counter runs 0..SLOT-1 across BLANK then DRIVE, so
  // the BLANK->DRIVE hand-off keeps counting instead of restarting.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    shadow_nxt = shadow;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt  = BLANK;
          cnt_nxt    = '0;
          idx_nxt    = '0;
          shadow_nxt = digits;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) state_nxt = DRIVE;
          cnt_nxt = cnt + CW'(1);
        end
        DRIVE: begin
          if (cnt == SLOT_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            if (idx == LAST_IDX) begin
              idx_nxt    = '0;
              shadow_nxt = digits;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are derived from the next-state values and registered with the
  // state, so they change on the same edge as the state they describe.
  assign digit_sel = shadow_nxt[idx_nxt];

  bcd7seg_lut u_lut (
    .bcd (digit_sel),
    .seg (seg_dec)
  );

  always_comb begin
    seg_nxt  = SEG_OFF;
    an_nxt   = '1;
    tick_nxt = 1'b0;
    if (state_nxt == DRIVE) begin
      seg_nxt          = seg_dec;
      an_nxt[idx_nxt]  = 1'b0;
      tick_nxt         = (cnt_nxt == SLOT_LAST) && (idx_nxt == LAST_IDX);
`ifdef DISP_LEADING_ZERO_BLANK_EN
      if ((idx_nxt != '0) && upper_zero(shadow_nxt, idx_nxt)) an_nxt = '1;
`endif
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      seg        <= SEG_OFF;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_tick <= tick_nxt;
    end
  end

  // Shadow digits are data only; they are always loaded before any DRIVE.
  always_ff @(posedge clk) begin
    shadow <= shadow_nxt;
  end

endmodule

// File: tb/tb_disp_scan_sched.sv
// tb_disp_scan_sched: directed self-checking bench for disp_scan_sched with
// SLOT = 8, ndig = 2, blank_cyc = 2 (16-cycle frames).
module tb_disp_scan_sched;

  localparam logic [6:0] P_OFF  = 7'h7F;
  localparam logic [6:0] P_DASH = 7'b0111111;
  localparam logic [6:0] P_0    = 7'b1000000;
  localparam logic [6:0] P_1    = 7'b1111001;
  localparam logic [6:0] P_2    = 7'b0100100;
  localparam logic [6:0] P_5    = 7'b0010010;
  localparam logic [6:0] P_7    = 7'b1111000;

`ifdef DISP_LEADING_ZERO_BLANK_EN
  localparam logic [1:0] AN1_ZERO = 2'b11;
`else
  localparam logic [1:0] AN1_ZERO = 2'b01;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] digits;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  int n_chk  = 0;
  int n_fail = 0;

  disp_scan_sched #(
    .fpga_freq  (80),
    .refresh_hz (10),
    .ndig       (2),
    .blank_cyc  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits     (digits),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_off(input string tag);
    chk({tag, " an"}, 32'(an), 32'(2'b11));
    chk({tag, " seg"}, 32'(seg), 32'(P_OFF));
    chk({tag, " tick"}, 32'(frame_tick), 32'd0);
  endtask

  // One frame of 16 edges. mode 1: change digits after cycle act;
  // mode 2: drop en after cycle act and return; mode 3: return after act.
  task automatic run_frame(input string tag, input logic [6:0] s0,
                           input logic [6:0] s1, input logic [1:0] an1,
                           input int act, input int mode,
                           input logic [7:0] val);
    logic [1:0] e_an;
    logic [6:0] e_seg;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (c < 2 || (c >= 8 && c < 10)) begin
        e_an  = 2'b11;
        e_seg = P_OFF;
      end else if (c < 8) begin
        e_an  = 2'b10;
        e_seg = s0;
      end else begin
        e_an  = an1;
        e_seg = s1;
      end
      chk($sformatf("%s an c%0d", tag, c), 32'(an), 32'(e_an));
      chk($sformatf("%s seg c%0d", tag, c), 32'(seg), 32'(e_seg));
      chk($sformatf("%s tick c%0d", tag, c), 32'(frame_tick),
          32'(c == 15));
      if (c == act) begin
        if (mode == 1) digits = val;
        if (mode == 2) begin
          en = 1'b0;
          return;
        end
        if (mode == 3) return;
      end
    end
  endtask

  initial begin
    int last;
    int ticks;
    rst    = 1'b0;
    en     = 1'b0;
    digits = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_off("reset");

    // basic scan of 57, digits change mid-frame
    en     = 1'b1;
    digits = 8'h57;
    @(negedge clk);
    rst = 1'b1;
    run_frame("f1", P_7, P_5, 2'b01, 5, 1, 8'h00);
    run_frame("f2", P_0, P_0, AN1_ZERO, -1, 0, 8'h00);

    // non-BCD code and a zero upper digit
    digits = 8'h0C;
    run_frame("f3", P_DASH, P_0, AN1_ZERO, -1, 0, 8'h00);

    // enable dropped mid-slot
    digits = 8'h57;
    run_frame("f4", P_7, P_5, 2'b01, 4, 2, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_off($sformatf("en_off %0d", k));
    end
    digits = 8'h12;
    en     = 1'b1;
    run_frame("f5", P_2, P_1, 2'b01, -1, 0, 8'h00);

    // asynchronous reset during digit 1 DRIVE
    run_frame("f6", P_2, P_1, 2'b01, 12, 3, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    chk_off("async_rst");
    @(posedge clk);
    #1;
    chk_off("rst_held");
    @(negedge clk);
    rst = 1'b1;
    run_frame("f7", P_2, P_1, 2'b01, -1, 0, 8'h00);

    // ten frames: tick period and one-hot-or-none anodes
    last  = -1;
    ticks = 0;
    for (int i = 0; i < 160; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("an_onehot %0d", i), 32'($countones(~an) <= 1), 32'd1);
      if (frame_tick) begin
        chk($sformatf("tick_gap %0d", i), 32'(i - last), 32'd16);
        last = i;
        ticks++;
      end
    end
    chk("tick_count", 32'(ticks), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
